// File: rtl/spi_sensor_poller_pkg.sv
// Shared definitions for the SPI sensor poller: FSM state encoding and
// frame-length arithmetic used to size the period counter.
package spi_sensor_poller_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;

  // Clocks from launch to the end of the inter-frame gap.
  function automatic int frame_len(input int setup, input int div, input int bits,
                                   input int hold, input int idle);
    return setup + 2 * div * bits + hold + idle;
  endfunction

endpackage

// File: rtl/spi_sensor_poller_half_tick.sv
// Half-period tick generator for SCK. Counts CLK_DIV clocks while run is high
// and pulses tick on the last one; held cleared whenever run is low so every
// frame starts its first half-period from a known phase.
module spi_sensor_poller_half_tick #(
  parameter int CLK_DIV = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == DIV_W'(CLK_DIV - 1));

  // Divider count: cleared outside SHIFT, wraps on every tick.
  always_ff @(posedge clock) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_sensor_poller.sv
// Read-only SPI master polling a serial sensor. One frame per start pulse or
// per auto-mode period; a bit field of the received frame is published with a
// one-cycle strobe.
//
// Handshake: start is a single-cycle request honoured only in IDLE (never
// queued); value_valid is a one-cycle strobe with no ready -- value is stable
// from that cycle until the next strobe (or reset).
module spi_sensor_poller
  import spi_sensor_poller_pkg::*;
#(
  parameter int FRAME_BITS = 16,
  parameter int VALUE_LSB  = 4,
  parameter int VALUE_W    = 8,
  parameter int CLK_DIV    = 8,
  parameter int CS_SETUP   = 8,
  parameter int CS_HOLD    = 8,
  parameter int CS_IDLE    = 16,
  parameter int PERIOD     = 4194304,
  parameter bit CPOL       = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  auto_en,
  input  logic                  start,
  output logic                  cs,
  output logic                  sck,
  input  logic                  sdo,
  output logic [VALUE_W-1:0]    value,
  output logic                  value_valid,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic [2:0]            dbg_state,
  output logic [FRAME_BITS-1:0] dbg_shreg
);

  localparam int DLY_MAX   = (CS_SETUP > CS_HOLD)
                             ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                             : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
  localparam int DLY_W     = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int BIT_W     = $clog2(FRAME_BITS);
  localparam int FRAME_LEN = frame_len(CS_SETUP, CLK_DIV, FRAME_BITS, CS_HOLD, CS_IDLE);
  localparam int PER_MAX   = (PERIOD > FRAME_LEN) ? PERIOD : FRAME_LEN;
  localparam int PER_W     = $clog2(PER_MAX);

  state_t                  state;
  logic [DLY_W-1:0]        dcnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic                    phase;     // 0 = idle half of the bit, 1 = active half
  logic [FRAME_BITS-1:0]   shreg;
  logic [PER_W-1:0]        per_cnt;
  logic                    auto_tick;
  logic                    half_tick;

  assign dbg_state = state;
  assign dbg_shreg = shreg;
  assign auto_tick = auto_en && (per_cnt == PER_W'(PERIOD - 1));

  spi_sensor_poller_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clock (clock),
    .reset (reset),
    .run   (state == ST_SHIFT),
    .tick  (half_tick)
  );

  // Auto-mode period counter: free-runs while enabled, wraps on each tick.
  always_ff @(posedge clock) begin
    if (reset || !auto_en) begin
      per_cnt <= '0;
    end else if (auto_tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // Frame sequencer: chip select, SCK generation, shifting and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cs          <= 1'b1;
      sck         <= CPOL;
      busy        <= 1'b0;
      dcnt        <= '0;
      bit_cnt     <= '0;
      phase       <= 1'b0;
      shreg       <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      value_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start || auto_tick) begin
            state <= ST_SETUP;
            cs    <= 1'b0;
            busy  <= 1'b1;
            dcnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (dcnt == DLY_W'(CS_SETUP - 1)) begin
            dcnt    <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            state   <= ST_SHIFT;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (half_tick) begin
            if (!phase) begin
              // Leading edge: sample the sensor on the same clock SCK goes active.
              sck   <= ~CPOL;
              shreg <= {shreg[FRAME_BITS-2:0], sdo};
              phase <= 1'b1;
            end else begin
              sck   <= CPOL;
              phase <= 1'b0;
              if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                dcnt  <= '0;
                state <= ST_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (dcnt == DLY_W'(CS_HOLD - 1)) begin
            cs          <= 1'b1;
            value       <= shreg[VALUE_LSB +: VALUE_W];
            value_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
            dcnt        <= '0;
            state       <= ST_GAP;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (dcnt == DLY_W'(CS_IDLE - 1)) begin
            busy  <= 1'b0;
            dcnt  <= '0;
            state <= ST_IDLE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cs    <= 1'b1;
          sck   <= CPOL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
